// File: rtl/mode4_adder_ctrl.sv
// Controller for a 4-input adder tree: two first-level adders, one second-level adder and an
// accumulator, fed one 4-element group per transfer, with a fixed two-cycle drain before done.
module mode4_adder_ctrl #(
    parameter int unsigned CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [CNTW-1:0] num_groups,
    input  logic            inp_valid,
    output logic            inp_ready,
    output logic            tree_clr,
    output logic            mode4_stage2_run,
    output logic            mode4_stage1_run,
    output logic            mode4_stage0_run,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] grp_cnt
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClear = 3'd1;
    localparam logic [2:0] StFeed  = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CNTW-1:0] num_q, num_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            drain_q, drain_d;
    logic            stage1_q, stage0_q;
    logic            xfer;
    logic            last_grp;

    assign xfer     = (state_q == StFeed) && inp_valid;
    // Compare against num-1 rather than counting past num so a full-scale count never wraps.
    assign last_grp = (cnt_q == (num_q - CNTW'(1)));

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    num_d   = num_groups;
                    cnt_d   = '0;
                    state_d = (num_groups == '0) ? StDone : StClear;
                end
            end
            StClear: state_d = StFeed;
            StFeed: begin
                if (xfer) begin
                    cnt_d = cnt_q + CNTW'(1);
                    if (last_grp) begin
                        state_d = StDrain;
                        drain_d = 1'b0;
                    end
                end
            end
            StDrain: begin
                drain_d = ~drain_q;
                if (drain_q) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            num_q    <= '0;
            cnt_q    <= '0;
            drain_q  <= 1'b0;
            stage1_q <= 1'b0;
            stage0_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            drain_q  <= drain_d;
            stage1_q <= xfer;
            stage0_q <= stage1_q;
        end
    end

    assign inp_ready        = (state_q == StFeed);
    assign tree_clr         = (state_q == StClear);
    assign mode4_stage2_run = xfer;
    assign mode4_stage1_run = stage1_q;
    assign mode4_stage0_run = stage0_q;
    assign busy             = (state_q != StIdle);
    assign done             = (state_q == StDone);
    assign grp_cnt          = cnt_q;

endmodule

// File: tb/tb_mode4_adder_ctrl.sv
// Directed bench for mode4_adder_ctrl: per-cycle expected outputs are queued as stimulus is
// driven and popped when the outputs are sampled mid-cycle.
module tb_mode4_adder_ctrl;

    typedef struct packed {
        logic       rdy;
        logic       clr;
        logic       s2;
        logic       s1;
        logic       s0;
        logic       busy;
        logic       done;
        logic [7:0] cnt;
    } out_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] num_groups;
    logic       inp_valid;
    logic       inp_ready, tree_clr, s2, s1, s0, busy, done;
    logic [7:0] grp_cnt;

    logic       start4;
    logic [3:0] ng4;
    logic       v4;
    logic       rdy4, clr4, s2_4, s1_4, s0_4, busy4, done4;
    logic [3:0] cnt4;

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    logic [7:0] last_cnt;

    mode4_adder_ctrl #(.CNTW(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .num_groups       (num_groups),
        .inp_valid        (inp_valid),
        .inp_ready        (inp_ready),
        .tree_clr         (tree_clr),
        .mode4_stage2_run (s2),
        .mode4_stage1_run (s1),
        .mode4_stage0_run (s0),
        .busy             (busy),
        .done             (done),
        .grp_cnt          (grp_cnt)
    );

    mode4_adder_ctrl #(.CNTW(4)) dut4 (
        .clk              (clk),
        .reset            (reset),
        .start            (start4),
        .num_groups       (ng4),
        .inp_valid        (v4),
        .inp_ready        (rdy4),
        .tree_clr         (clr4),
        .mode4_stage2_run (s2_4),
        .mode4_stage1_run (s1_4),
        .mode4_stage0_run (s0_4),
        .busy             (busy4),
        .done             (done4),
        .grp_cnt          (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t observed();
        out_t o;
        o = '{rdy: inp_ready, clr: tree_clr, s2: s2, s1: s1, s0: s0, busy: busy, done: done,
              cnt: grp_cnt};
        return o;
    endfunction

    task automatic check_out(input string tag);
        out_t e;
        out_t o;
        e = exp_q.pop_front();
        o = observed();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s rdy/clr/s2/s1/s0/busy/done/cnt observed=%b required=%b",
                   tag, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, req);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check that cycle's outputs.
    task automatic drive_check(input string tag, input logic st, input logic [7:0] ng,
                               input logic v, input out_t e);
        @(negedge clk);
        start      = st;
        num_groups = ng;
        inp_valid  = v;
        exp_q.push_back(e);
        #1;
        check_out(tag);
    endtask

    task automatic run_reduction(input string tag, input int n, input logic [15:0] vpat,
                                 input int vlen, input int mid_k);
        out_t e;
        logic p1, p2, v;
        int   trans, k;
        e = '0;
        e.cnt = last_cnt;
        drive_check(tag, 1'b1, n[7:0], 1'b0, e);
        if (n == 0) begin
            e = '0;
            e.busy = 1'b1;
            e.done = 1'b1;
            drive_check(tag, 1'b0, 8'd0, 1'b1, e);
        end else begin
            e = '0;
            e.clr  = 1'b1;
            e.busy = 1'b1;
            drive_check(tag, 1'b0, n[7:0], 1'b1, e);
            p1 = 1'b0;
            p2 = 1'b0;
            trans = 0;
            k = 0;
            while (trans < n) begin
                v = (k < vlen) ? vpat[k[3:0]] : 1'b1;
                e = '0;
                e.rdy  = 1'b1;
                e.s2   = v;
                e.s1   = p2;
                e.s0   = p1;
                e.busy = 1'b1;
                e.cnt  = trans[7:0];
                drive_check(tag, logic'(k == mid_k), (k == mid_k) ? 8'd9 : n[7:0], v, e);
                p1 = p2;
                p2 = v;
                trans += int'(v);
                k++;
            end
            // Two drain cycles then done; inp_valid stays high and must be refused.
            for (int d = 0; d < 3; d++) begin
                e = '0;
                e.s1   = p2;
                e.s0   = p1;
                e.busy = 1'b1;
                e.done = (d == 2);
                e.cnt  = n[7:0];
                drive_check(tag, 1'b0, n[7:0], 1'b1, e);
                p1 = p2;
                p2 = 1'b0;
            end
        end
        e = '0;
        e.cnt = n[7:0];
        drive_check(tag, 1'b0, n[7:0], 1'b1, e);
        last_cnt = n[7:0];
    endtask

    initial begin
        out_t e;
        int   c2, c1, c0, cd, final4;
        reset      = 1'b1;
        start      = 1'b0;
        num_groups = 8'd0;
        inp_valid  = 1'b0;
        start4     = 1'b0;
        ng4        = 4'd0;
        v4         = 1'b0;
        last_cnt   = 8'd0;

        #2;
        exp_q.push_back(out_t'(0));
        check_out("reset_state");
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_q.push_back(out_t'(0));
        check_out("after_release");

        run_reduction("n4_full",   4,   16'h0000, 0,  -1);
        run_reduction("n3_bubble", 3,   16'h0015, 5,  -1);
        run_reduction("n0",        0,   16'h0000, 0,  -1);
        run_reduction("n2_restart", 2,  16'h0005, 3,   1);
        run_reduction("n255_max",  255, 16'h0000, 0,  -1);

        // Asynchronous reset mid-FEED after two of five transfers.
        e = '0;
        e.cnt = last_cnt;
        drive_check("rst_start", 1'b1, 8'd5, 1'b0, e);
        e = '0; e.clr = 1'b1; e.busy = 1'b1;
        drive_check("rst_clear", 1'b0, 8'd5, 1'b1, e);
        e = '0; e.rdy = 1'b1; e.s2 = 1'b1; e.busy = 1'b1; e.cnt = 8'd0;
        drive_check("rst_x0", 1'b0, 8'd5, 1'b1, e);
        e = '0; e.rdy = 1'b1; e.s2 = 1'b1; e.s1 = 1'b1; e.busy = 1'b1; e.cnt = 8'd1;
        drive_check("rst_x1", 1'b0, 8'd5, 1'b1, e);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        exp_q.push_back(out_t'(0));
        check_out("rst_async_zero");
        @(posedge clk);
        #1;
        exp_q.push_back(out_t'(0));
        check_out("rst_held");
        @(negedge clk);
        reset = 1'b0;
        last_cnt = 8'd0;
        for (int i = 0; i < 4; i++) begin
            drive_check("rst_idle_no_done", 1'b0, 8'd5, 1'b1, out_t'(0));
        end

        // Full-scale count on a 4-bit instance.
        c2 = 0; c1 = 0; c0 = 0; cd = 0; final4 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start4 = (i == 0);
            ng4    = 4'd15;
            v4     = 1'b1;
            #1;
            c2 += int'(s2_4);
            c1 += int'(s1_4);
            c0 += int'(s0_4);
            if (done4) begin
                cd++;
                final4 = int'(cnt4);
            end
        end
        check_int("w4_stage2_cnt", c2, 15);
        check_int("w4_stage1_cnt", c1, 15);
        check_int("w4_stage0_cnt", c0, 15);
        check_int("w4_done_cnt",   cd, 1);
        check_int("w4_grp_cnt",    final4, 15);
        check_int("w4_idle_cnt",   int'(cnt4), 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mode4_adder_ctrl.md
MODE4_ADDER_CTRL -- requirements
Module: mode4_adder_ctrl

Interface
REQ-001: Parameter CNTW, default 8, bit width of group count and group counter.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004: start  input  1  begin a reduction of num_groups 4-element groups; sampled only in IDLE.
REQ-005: num_groups  input  CNTW  number of groups in the vector; latched on accepted start.
REQ-006: inp_valid  input  1  upstream has a 4-element group on the adder-tree inputs this cycle.
REQ-007: inp_ready  output  1  controller accepts a group this cycle.
REQ-008: tree_clr  output  1  one-cycle clear pulse to the adder tree's reset input.
REQ-009: mode4_stage2_run  output  1  capture enable for the two first-level adders.
REQ-010: mode4_stage1_run  output  1  capture enable for the second-level adder.
REQ-011: mode4_stage0_run  output  1  capture enable for the accumulator.
REQ-012: busy  output  1  high in every state except IDLE.
REQ-013: done  output  1  one-cycle pulse; accumulator output is final this cycle.
REQ-014: grp_cnt  output  CNTW  groups accepted since the last accepted start.

Function
REQ-015: FSM states: IDLE, CLEAR, FEED, DRAIN, DONE; state, counters and pipeline flags are registers.
REQ-016: IDLE: start=1 and num_groups!=0 -> CLEAR; num_groups latched, grp_cnt cleared to 0.
REQ-017: IDLE: start=1 and num_groups==0 -> DONE directly; no tree_clr, no run strobes.
REQ-018: CLEAR: tree_clr=1 for exactly this cycle; next state FEED unconditionally.
REQ-019: FEED: inp_ready=1; in all other states inp_ready=0.
REQ-020: mode4_stage2_run = (state==FEED) & inp_valid, combinational; a transfer occurs when it is 1.
REQ-021: Each transfer increments grp_cnt by 1 on the same edge.
REQ-022: inp_valid low in FEED inserts a bubble; FSM stays in FEED, grp_cnt holds.
REQ-023: mode4_stage1_run is mode4_stage2_run delayed one cycle through a register.
REQ-024: mode4_stage0_run is mode4_stage1_run delayed one cycle through a register.
REQ-025: Exactly one stage1 and one stage0 strobe follow every stage2 strobe, bubbles preserved.
REQ-026: Transfer when grp_cnt==latched num_groups-1 -> DRAIN; no further transfers accepted.
REQ-027: DRAIN: lasts exactly 2 cycles (a 1-bit counter), covering the final stage1 and stage0 strobes; then -> DONE.
REQ-028: DONE: done=1 for one cycle; next state IDLE; grp_cnt holds its final value until next accepted start.
REQ-029: Last transfer at cycle t: stage1 strobe at t+1, stage0 strobe at t+2, done at t+3.
REQ-030: start asserted while busy is ignored; num_groups changes while busy are ignored.
REQ-031: num_groups = 2^CNTW-1 (max) SHALL complete without counter wrap.
REQ-032: done and tree_clr never assert in the same cycle; run strobes are 0 in IDLE, CLEAR and DONE, except trailing delayed strobes as in REQ-029.

Reset
REQ-033: reset=1: state IDLE, grp_cnt=0, delay registers 0, DRAIN counter 0, immediately, regardless of clk.
REQ-034: While reset=1 all outputs SHALL be 0 (inp_ready, tree_clr, all run strobes, busy, done).
REQ-035: Reset mid-FEED or mid-DRAIN aborts the reduction; no done pulse; first cycle after release is IDLE.

Verification
REQ-036: num_groups=4, inp_valid held 1 -> tree_clr at cycle 1, stage2 strobes cycles 2-5, stage1 3-6, stage0 4-7, done at cycle 8, grp_cnt=4.
REQ-037: num_groups=3, inp_valid pattern 1,0,1,0,1 -> exactly 3 strobes per stage with bubbles mirrored 1 and 2 cycles later, done 3 cycles after last transfer.
REQ-038: num_groups=0 with start -> done one cycle later, no tree_clr, no run strobes, grp_cnt=0.
REQ-039: start pulsed again during FEED with num_groups=9 -> ignored; original count of 2 completes, grp_cnt=2.
REQ-040: reset asserted between clock edges during FEED after 2 of 5 transfers -> all outputs 0 at once, IDLE after release, no done.
REQ-041: CNTW=4, num_groups=15 -> 15 transfers, grp_cnt=15, single done, no wrap.
